// File: rtl/memory_defs.sv
// Shared encodings for the load/store access controller.
package memory_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/memory_lane_encoder.sv
// Maps access size and low address bits to byte lanes, shifted store data and fault flags.
module memory_lane_encoder
  import memory_defs::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        misaccess_o
);

  always_comb begin
    byte_en_o    = 4'b0000;
    misaligned_o = 1'b0;
    misaccess_o  = 1'b0;
    wdata_o      = wdata_i << {addr_i, 3'b000};
    unique case (size_i)
      SIZE_BYTE: byte_en_o = 4'b0001 << addr_i;
      SIZE_HALF: begin
        if (addr_i == 2'b11) misaligned_o = 1'b1;
        else                 byte_en_o    = 4'b0011 << addr_i;
      end
      SIZE_WORD: begin
        if (addr_i != 2'b00) misaligned_o = 1'b1;
        else                 byte_en_o    = 4'b1111;
      end
      default:   misaccess_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// Single-outstanding load/store controller: alignment check, memory handshake with timeout,
// and a registered response carrying the raw read word for the downstream load mutator.
module memory_access_ctrl
  import memory_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_rw_i,
  input  logic              req_sign_i,
  input  logic [1:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_byte_en_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_rw_o,
  output logic              rsp_sign_o,
  output logic [1:0]        rsp_size_o,
  output logic [3:0]        rsp_byte_en_o,
  output logic [31:0]       rsp_rddata_o,
  output logic              rsp_misaligned_o,
  output logic              rsp_misaccess_o,
  output logic              rsp_timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rw_q, rw_d, sign_q, sign_d, we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, rddata_q, rddata_d;
  logic              misal_q, misal_d, misacc_q, misacc_d, tmo_q, tmo_d;

  logic [3:0]  enc_be;
  logic [31:0] enc_wdata;
  logic        enc_misal, enc_misacc;

  memory_lane_encoder u_lane_enc (
    .size_i       (req_size_i),
    .addr_i       (req_addr_i[1:0]),
    .wdata_i      (req_wdata_i),
    .byte_en_o    (enc_be),
    .wdata_o      (enc_wdata),
    .misaligned_o (enc_misal),
    .misaccess_o  (enc_misacc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    sign_d   = sign_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rddata_d = rddata_q;
    misal_d  = misal_q;
    misacc_d = misacc_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          rw_d     = req_rw_i;
          sign_d   = req_sign_i;
          we_d     = ~req_rw_i;
          size_d   = req_size_i;
          addr_d   = {req_addr_i[ADDR_W-1:2], 2'b00};
          be_d     = enc_be;
          wdata_d  = enc_wdata;
          rddata_d = 32'h0;
          misal_d  = enc_misal;
          misacc_d = enc_misacc;
          tmo_d    = 1'b0;
          cnt_d    = '0;
          state_d  = (enc_misal || enc_misacc) ? StResp : StAccess;
        end
      end
      StAccess: begin
        // Ack takes priority over a timeout reached on the same edge.
        if (mem_ack_i) begin
          rddata_d = rw_q ? mem_rdata_i : 32'h0;
          state_d  = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          misal_d  = 1'b0;
          misacc_d = 1'b0;
          tmo_d    = 1'b0;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rddata_q <= 32'h0;
      misal_q  <= 1'b0;
      misacc_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      sign_q   <= sign_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rddata_q <= rddata_d;
      misal_q  <= misal_d;
      misacc_q <= misacc_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready_o      = (state_q == StIdle);
  assign mem_req_o        = (state_q == StAccess);
  assign rsp_valid_o      = (state_q == StResp);
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_byte_en_o    = be_q;
  assign mem_wdata_o      = wdata_q;
  assign rsp_rw_o         = rw_q;
  assign rsp_sign_o       = sign_q;
  assign rsp_size_o       = size_q;
  assign rsp_byte_en_o    = be_q;
  assign rsp_rddata_o     = rddata_q;
  assign rsp_misaligned_o = misal_q;
  assign rsp_misaccess_o  = misacc_q;
  assign rsp_timeout_o    = tmo_q;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Directed self-checking bench for memory_access_ctrl with a 4-cycle bus timeout.
module tb_memory_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_rw = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_ack = 1'b0, rsp_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        req_ready, mem_req, mem_we, rsp_valid, rsp_rw, rsp_sign;
  logic        rsp_misaligned, rsp_misaccess, rsp_timeout;
  logic [31:0] mem_addr, mem_wdata, rsp_rddata;
  logic [3:0]  mem_byte_en, rsp_byte_en;
  logic [1:0]  rsp_size;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  memory_access_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_sign_i(req_sign), .req_size_i(req_size), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_byte_en_o(mem_byte_en), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rw_o(rsp_rw),
    .rsp_sign_o(rsp_sign), .rsp_size_o(rsp_size), .rsp_byte_en_o(rsp_byte_en),
    .rsp_rddata_o(rsp_rddata), .rsp_misaligned_o(rsp_misaligned),
    .rsp_misaccess_o(rsp_misaccess), .rsp_timeout_o(rsp_timeout)
  );

  // Present a request for exactly one clock edge; returns at the following negedge.
  task automatic issue(input logic rw, input logic sgn, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_rw = rw; req_sign = sgn; req_size = sz;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", req_ready); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_memreq got %b want 0", mem_req); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rspvalid got %b want 0", rsp_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    issue(1'b1, 1'b1, 2'b01, 32'h0000_1003, 32'h0);
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL lb_memreq got %b want 1", mem_req); end
    nvec++; if (mem_addr !== 32'h1000) begin nerr++; $display("FAIL lb_addr got %h want 00001000", mem_addr); end
    nvec++; if (mem_byte_en !== 4'b1000) begin nerr++; $display("FAIL lb_be got %b want 1000", mem_byte_en); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL lb_we got %b want 0", mem_we); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL lb_memreq_drop got %b want 0", mem_req); end
    nvec++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL lb_rspvalid got %b want 1", rsp_valid); end
    nvec++; if (rsp_rddata !== 32'h80FF_1234) begin nerr++; $display("FAIL lb_rddata got %h want 80ff1234", rsp_rddata); end
    nvec++; if (rsp_byte_en !== 4'b1000) begin nerr++; $display("FAIL lb_rspbe got %b want 1000", rsp_byte_en); end
    nvec++; if ({rsp_rw, rsp_sign, rsp_size} !== 4'b1101) begin nerr++; $display("FAIL lb_fields got %b want 1101", {rsp_rw, rsp_sign, rsp_size}); end
    handshake();
    nvec++; if ({req_ready, rsp_valid} !== 2'b10) begin nerr++; $display("FAIL lb_done got %b want 10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b0, 2'b10, 32'h0000_2002, 32'h0000_ABCD);
    nvec++; if (mem_we !== 1'b1) begin nerr++; $display("FAIL sh_we got %b want 1", mem_we); end
    nvec++; if (mem_byte_en !== 4'b1100) begin nerr++; $display("FAIL sh_be got %b want 1100", mem_byte_en); end
    nvec++; if (mem_wdata !== 32'hABCD_0000) begin nerr++; $display("FAIL sh_wdata got %h want abcd0000", mem_wdata); end
    nvec++; if (mem_addr !== 32'h2000) begin nerr++; $display("FAIL sh_addr got %h want 00002000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    nvec++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL sh_rspvalid got %b want 1", rsp_valid); end
    nvec++; if (rsp_rddata !== 32'h0) begin nerr++; $display("FAIL sh_rddata got %h want 00000000", rsp_rddata); end
    handshake();
  endtask

  task automatic test_faults();
    issue(1'b1, 1'b0, 2'b11, 32'h0000_3001, 32'h0);
    nvec++; if ({rsp_valid, rsp_misaligned, rsp_misaccess} !== 3'b110) begin nerr++; $display("FAIL mis_flags got %b want 110", {rsp_valid, rsp_misaligned, rsp_misaccess}); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL mis_memreq got %b want 0", mem_req); end
    nvec++; if (rsp_byte_en !== 4'b0000) begin nerr++; $display("FAIL mis_be got %b want 0000", rsp_byte_en); end
    handshake();
    nvec++; if (rsp_misaligned !== 1'b0) begin nerr++; $display("FAIL mis_clear got %b want 0", rsp_misaligned); end
    issue(1'b1, 1'b0, 2'b00, 32'h0000_3000, 32'h0);
    nvec++; if ({rsp_valid, rsp_misaligned, rsp_misaccess} !== 3'b101) begin nerr++; $display("FAIL acc_flags got %b want 101", {rsp_valid, rsp_misaligned, rsp_misaccess}); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL acc_memreq got %b want 0", mem_req); end
    handshake();
    issue(1'b1, 1'b0, 2'b10, 32'h0000_3003, 32'h0);
    nvec++; if ({rsp_valid, rsp_misaligned, mem_req} !== 3'b110) begin nerr++; $display("FAIL half3_flags got %b want 110", {rsp_valid, rsp_misaligned, mem_req}); end
    handshake();
  endtask

  task automatic test_timeout();
    issue(1'b1, 1'b0, 2'b11, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL to_memreq[%0d] got %b want 1", i, mem_req); end
      @(negedge clk);
    end
    nvec++; if ({mem_req, rsp_valid, rsp_timeout} !== 3'b011) begin nerr++; $display("FAIL to_flags got %b want 011", {mem_req, rsp_valid, rsp_timeout}); end
    nvec++; if (rsp_rddata !== 32'h0) begin nerr++; $display("FAIL to_rddata got %h want 00000000", rsp_rddata); end
    handshake();
    nvec++; if (rsp_timeout !== 1'b0) begin nerr++; $display("FAIL to_clear got %b want 0", rsp_timeout); end
    issue(1'b1, 1'b0, 2'b11, 32'h0000_4004, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL ta_memreq[%0d] got %b want 1", i, mem_req); end
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    nvec++; if ({rsp_valid, rsp_timeout} !== 2'b10) begin nerr++; $display("FAIL ta_flags got %b want 10", {rsp_valid, rsp_timeout}); end
    nvec++; if (rsp_rddata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL ta_rddata got %h want cafef00d", rsp_rddata); end
    handshake();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 2'b01, 32'h0000_5001, 32'h0000_005A);
    nvec++; if (mem_wdata !== 32'h0000_5A00) begin nerr++; $display("FAIL bp_wdata got %h want 00005a00", mem_wdata); end
    nvec++; if (mem_byte_en !== 4'b0010) begin nerr++; $display("FAIL bp_be got %b want 0010", mem_byte_en); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    req_valid = 1'b1; req_rw = 1'b1; req_sign = 1'b0; req_size = 2'b01;
    req_addr = 32'h0000_6000; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      nvec++; if ({rsp_valid, req_ready, mem_req} !== 3'b100) begin nerr++; $display("FAIL bp_hold[%0d] got %b want 100", i, {rsp_valid, req_ready, mem_req}); end
      nvec++; if ({rsp_byte_en, rsp_rw, rsp_size} !== 7'b0010001) begin nerr++; $display("FAIL bp_stable[%0d] got %b want 0010001", i, {rsp_byte_en, rsp_rw, rsp_size}); end
      @(negedge clk);
    end
    handshake();
    nvec++; if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin nerr++; $display("FAIL bp_release got %b want 100", {req_ready, rsp_valid, mem_req}); end
    @(negedge clk);
    req_valid = 1'b0;
    nvec++; if ({mem_req, mem_addr, mem_byte_en} !== {1'b1, 32'h0000_6000, 4'b0001}) begin nerr++; $display("FAIL bp_next got %h want 1000060001", {mem_req, mem_addr, mem_byte_en}); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_00A5;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    nvec++; if (rsp_rddata !== 32'h0000_00A5) begin nerr++; $display("FAIL bp_rddata got %h want 000000a5", rsp_rddata); end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 2'b11, 32'h0000_7000, 32'h0);
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL rm_pre got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    nvec++; if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin nerr++; $display("FAIL rm_async got %b want 001", {mem_req, rsp_valid, req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++; if ({req_ready, mem_req} !== 2'b10) begin nerr++; $display("FAIL rm_after got %b want 10", {req_ready, mem_req}); end
    issue(1'b1, 1'b1, 2'b01, 32'h0000_7002, 32'h0);
    nvec++; if ({mem_req, mem_byte_en} !== 5'b10100) begin nerr++; $display("FAIL rm_req got %b want 10100", {mem_req, mem_byte_en}); end
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    nvec++; if ({rsp_valid, rsp_rddata} !== {1'b1, 32'h1122_3344}) begin nerr++; $display("FAIL rm_rsp got %h want 111223344", {rsp_valid, rsp_rddata}); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_access_ctrl.md
Name: memory_access_ctrl

Overview:
Sequential load/store access controller between the execute stage and the data memory port. Accepts one access request, checks alignment, generates the word address, byte enables and lane-shifted store data, then runs the memory handshake. For loads it captures the raw 32-bit read word plus the byte enables, size and sign. These feed the downstream load-data mutator, which extracts and extends the loaded value. It issues one outstanding access at a time, with a bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ack before aborting with rsp_timeout (min 1)
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present from pipeline
req_ready  out  1  controller can accept (state IDLE)
req_rw  in  1  1 = load (read), 0 = store
req_sign  in  1  sign-extend on load (passed through)
req_size  in  2  01 byte, 10 half, 11 word, 00 invalid
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
mem_req  out  1  memory request strobe, held until ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address {req_addr[ADDR_W-1:2],2'b00}
mem_byte_en  out  4  active byte lanes
mem_wdata  out  32  lane-shifted store data
mem_ack  in  1  memory completion, one cycle pulse
mem_rdata  in  32  read word, valid with mem_ack
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rw / rsp_sign / rsp_size  out  1/1/2  registered copies of the request fields
rsp_byte_en  out  4  byte enables of the completed access
rsp_rddata  out  32  raw captured mem_rdata (0 for stores/faults)
rsp_misaligned  out  1  alignment fault, no memory access made
rsp_misaccess  out  1  req_size==00, no memory access made
rsp_timeout  out  1  access aborted after TIMEOUT_CYCLES

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0 except req_ready=1; timeout counter=0. An in-flight mem_req drops immediately.
- Byte enables: byte -> 4'b0001<<addr[1:0]. Half: addr[1:0]=00->0011, 01->0110, 10->1100, 11->misaligned. Word: 00->1111, else misaligned. Size 00 -> misaccess.
- Store data: mem_wdata = req_wdata << (8*addr[1:0]), truncated to 32 bits.
- All mem_* and rsp_* outputs are registered; request fields are latched on acceptance (req_valid & req_ready).
- FSM IDLE: on acceptance with no fault -> ACCESS, mem_req=1 from the next cycle. On acceptance with a fault -> RESP, setting rsp_misaligned or rsp_misaccess, rsp_byte_en=0, and mem_req is never raised.
- FSM ACCESS: mem_req, mem_we, mem_addr, mem_byte_en and mem_wdata stay stable.
  - On mem_ack: mem_req=0 next cycle; rsp_rddata=mem_rdata if load, else 0; go to RESP.
  - Counter increments each cycle without ack. When the count reaches TIMEOUT_CYCLES: rsp_timeout=1, mem_req=0, go to RESP.
  - If mem_ack arrives in the same cycle the timeout is reached, ack wins (no timeout).
- FSM RESP: rsp_valid=1 with stable fields until rsp_ready. On the handshake: rsp_valid=0, all flags cleared, counter cleared, go to IDLE. req_ready rises the same edge.
- Latency: acceptance at edge N; mem_req visible after N. Ack sampled at edge N+1 at the earliest -> rsp_valid after N+1. Back-to-back throughput is at best one access per 3 cycles.
- mem_ack outside ACCESS is ignored. req_valid outside IDLE is ignored (req_ready=0).

Decomposition:
- Package memory_defs:
  - size encodings (SIZE_BYTE=2'b01, SIZE_HALF=2'b10, SIZE_WORD=2'b11)
  - state encoding (IDLE, ACCESS, RESP)
  - default TIMEOUT_CYCLES
- One combinational sub-module, memory_lane_encoder: (size, addr[1:0], wdata) -> byte_en, shifted wdata, misaligned, misaccess.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Load byte, addr 0x1003, sign=1, mem_rdata=0x80FF_1234 acked after 2 cycles -> mem_addr=0x1000, mem_byte_en=1000, rsp_rddata=0x80FF1234, rsp_byte_en=1000, rsp_sign=1.
- Store half, addr 0x2002, wdata=0x0000_ABCD -> mem_we=1, mem_byte_en=1100, mem_wdata=0xABCD0000; rsp_valid with rsp_rddata=0.
- Load word at addr 0x3001 -> rsp_misaligned=1 one cycle after acceptance, mem_req never asserted. Then req_size=00 -> rsp_misaccess=1.
- TIMEOUT_CYCLES=4, no mem_ack -> mem_req high exactly 4 cycles, then rsp_timeout=1. Repeat with ack on the 4th cycle -> normal response, rsp_timeout=0.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, req_ready=0, a new req_valid is not accepted. Release -> accepted the cycle after the handshake.
- Assert rst mid-ACCESS -> mem_req=0 and rsp_valid=0 immediately (async); after release, req_ready=1 and a subsequent load completes normally.
